// File: rtl/trig_pkg.sv
// trig_pkg: shared state encoding, timing and width constants for the trigger generator
package trig_pkg;
  localparam int CLK_NS = 10;
  localparam int CYCLE_W = 20;
  localparam int PULSE_W = 12;
  localparam int CNT_W = 16;
  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_PULSE    = 4'b0010,
    S_GAP      = 4'b0100,
    S_WAIT_EXT = 4'b1000
  } state_t;
  function automatic logic [CYCLE_W-1:0] eff_cycle(input logic [CYCLE_W-1:0] c, input logic [CYCLE_W-1:0] m);
    return (c < m) ? m : c;
  endfunction
  // Width is capped one below the period so every frame keeps at least one GAP cycle.
  function automatic logic [PULSE_W-1:0] eff_pulse(input logic [CYCLE_W-1:0] ce, input logic [PULSE_W-1:0] p);
    logic [CYCLE_W-1:0] lim;
    lim = ce - CYCLE_W'(1);
    return (CYCLE_W'(p) > lim) ? lim[PULSE_W-1:0] : p;
  endfunction
endpackage

// File: rtl/trig_gen_if.sv
// trig_gen_if: command/acquisition bundle of the trigger generator
//   master: drives i_run, i_outmode, i_outnegedge, i_cycle, i_pulse, i_ext_trig; reads o_*
//   slave : trig_gen side
interface trig_gen_if;
  import trig_pkg::*;
  logic i_run;
  logic i_outmode;
  logic i_outnegedge;
  logic [CYCLE_W-1:0] i_cycle;
  logic [PULSE_W-1:0] i_pulse;
  logic i_ext_trig;
  logic o_trig;
  logic o_frame_start;
  logic [CNT_W-1:0] o_frame_cnt;
  logic o_busy;
  modport master(
    output i_run, i_outmode, i_outnegedge, i_cycle, i_pulse, i_ext_trig,
    input  o_trig, o_frame_start, o_frame_cnt, o_busy
  );
  modport slave(
    input  i_run, i_outmode, i_outnegedge, i_cycle, i_pulse, i_ext_trig,
    output o_trig, o_frame_start, o_frame_cnt, o_busy
  );
endinterface

// File: rtl/edge_sync.sv
// edge_sync: synchronizer chain plus registered rise/fall strobes for an async input
//   i_clk, i_rst_n : clock, async active-low reset
//   i_d            : asynchronous input
//   o_rise, o_fall : one-clock strobes, suppressed for SYNC_STAGES+1 clocks after reset
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic [SYNC_STAGES:0] arm;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      arm <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_d};
      prev <= sync[SYNC_STAGES-1];
      arm <= {arm[SYNC_STAGES-1:0], 1'b1};
      // arm blocks the spurious edge seen while the chain fills after reset
      o_rise <= arm[SYNC_STAGES] & sync[SYNC_STAGES-1] & ~prev;
      o_fall <= arm[SYNC_STAGES] & ~sync[SYNC_STAGES-1] & prev;
    end
endmodule

// File: rtl/trig_gen.sv
// trig_gen: periodic or externally triggered transducer fire pulse generator
//   i_clk, i_rst_n : 100 MHz clock, async active-low reset
//   bus (slave)    : run/mode/edge/period/width/ext trigger in; trig, frame strobe, frame count, busy out
module trig_gen
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_CYCLE = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  trig_gen_if.slave bus
);
  localparam logic [CYCLE_W-1:0] MIN_C = CYCLE_W'(MIN_CYCLE < 2 ? 2 : MIN_CYCLE);
  state_t state, state_n;
  logic sh_mode;
  logic [CYCLE_W-1:0] sh_ce, pcnt, ce_in;
  logic [PULSE_W-1:0] sh_pe, wcnt, pe_in;
  logic [CNT_W-1:0] frame_cnt;
  logic trig_q, fs_q, busy_q;
  logic rise, fall, edge_hit, pulse_done, period_done, start;
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_d(bus.i_ext_trig),
    .o_rise(rise),
    .o_fall(fall)
  );
  assign bus.o_trig = trig_q;
  assign bus.o_frame_start = fs_q;
  assign bus.o_frame_cnt = frame_cnt;
  assign bus.o_busy = busy_q;
  always_comb begin
    ce_in = eff_cycle(bus.i_cycle, MIN_C);
    pe_in = eff_pulse(ce_in, bus.i_pulse);
    edge_hit = bus.i_outnegedge ? fall : rise;
    // a zero width still spends one PULSE cycle so the frame strobe fires
    pulse_done = (wcnt + PULSE_W'(1)) >= sh_pe;
    period_done = pcnt == (sh_ce - CYCLE_W'(1));
    state_n = state;
    if (!bus.i_run) state_n = S_IDLE;
    else
      unique case (state)
        S_IDLE:     state_n = bus.i_outmode ? S_WAIT_EXT : S_PULSE;
        S_PULSE:    state_n = pulse_done ? (sh_mode ? S_WAIT_EXT : S_GAP) : S_PULSE;
        S_GAP:      state_n = period_done ? S_PULSE : S_GAP;
        S_WAIT_EXT: state_n = edge_hit ? S_PULSE : S_WAIT_EXT;
        default:    state_n = S_IDLE;
      endcase
    start = (state_n == S_PULSE) && (state != S_PULSE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_IDLE;
      sh_mode <= 1'b0;
      sh_ce <= '0;
      sh_pe <= '0;
      pcnt <= '0;
      wcnt <= '0;
      frame_cnt <= '0;
      trig_q <= 1'b0;
      fs_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      fs_q <= start;
      busy_q <= state_n != S_IDLE;
      // staying in PULSE already implies remaining width, so only entry needs the Pe=0 test
      trig_q <= start ? (pe_in != '0) : (state_n == S_PULSE);
      if (start) begin
        sh_mode <= bus.i_outmode;
        sh_ce <= ce_in;
        sh_pe <= pe_in;
        pcnt <= '0;
        wcnt <= '0;
      end else begin
        pcnt <= (state_n == S_PULSE || state_n == S_GAP) ? pcnt + CYCLE_W'(1) : '0;
        wcnt <= (state_n == S_PULSE) ? wcnt + PULSE_W'(1) : '0;
      end
      if (state == S_IDLE && state_n != S_IDLE) frame_cnt <= start ? CNT_W'(1) : '0;
      else if (start) frame_cnt <= frame_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_trig_gen.sv
// tb_trig_gen: directed self-checking bench for trig_gen
module tb_trig_gen;
  import trig_pkg::*;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int fs_q[$];
  int w_q[$];
  int t_now = 0;
  trig_gen_if bus();
  trig_gen #(.SYNC_STAGES(2), .MIN_CYCLE(2)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .bus(bus)
  );
  always #(CLK_NS / 2) i_clk = ~i_clk;
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask
  task automatic clear();
    fs_q.delete();
    w_q.delete();
    t_now = 0;
  endtask
  task automatic measure(input int n);
    repeat (n) begin
      tick();
      t_now++;
      if (bus.o_frame_start) begin
        fs_q.push_back(t_now);
        w_q.push_back(0);
      end
      if (bus.o_trig && w_q.size() > 0) w_q[w_q.size()-1] = w_q[w_q.size()-1] + 1;
    end
  endtask
  function automatic int fs_at(input int k);
    return k < fs_q.size() ? fs_q[k] : -1;
  endfunction
  function automatic int w_at(input int k);
    return k < w_q.size() ? w_q[k] : -1;
  endfunction
  task automatic setup(input logic mode, input logic neg, input int cyc, input int pul);
    bus.i_outmode = mode;
    bus.i_outnegedge = neg;
    bus.i_cycle = CYCLE_W'(cyc);
    bus.i_pulse = PULSE_W'(pul);
  endtask
  task automatic stop();
    bus.i_run = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    i_rst_n = 1'b0;
    bus.i_run = 1'b0;
    bus.i_ext_trig = 1'b0;
    setup(1'b0, 1'b0, 100, 10);
    repeat (3) @(negedge i_clk);
    n_tests++; if (bus.o_trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %0b exp 0", bus.o_trig); end
    n_tests++; if (bus.o_frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %0b exp 0", bus.o_frame_start); end
    n_tests++; if (bus.o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", bus.o_frame_cnt); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b exp 0", bus.o_busy); end
    i_rst_n = 1'b1;
    repeat (2) tick();
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b exp 0", bus.o_busy); end
  endtask
  task automatic test_startup();
    i_rst_n = 1'b0;
    bus.i_ext_trig = 1'b1;
    bus.i_run = 1'b1;
    setup(1'b1, 1'b0, 1000, 5);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear();
    measure(12);
    n_tests++; if (fs_q.size() !== 0) begin n_fail++; $display("FAIL startup_suppress: got %0d frames exp 0", fs_q.size()); end
    n_tests++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL startup_wait_busy: got %0b exp 1", bus.o_busy); end
    bus.i_ext_trig = 1'b0;
    measure(4);
    clear();
    bus.i_ext_trig = 1'b1;
    measure(10);
    n_tests++; if (fs_q.size() !== 1 || fs_at(0) !== 4) begin n_fail++; $display("FAIL ext_rise_latency: got %0d frames first at %0d exp 1 at 4", fs_q.size(), fs_at(0)); end
    n_tests++; if (w_at(0) !== 5) begin n_fail++; $display("FAIL ext_rise_width: got %0d exp 5", w_at(0)); end
    stop();
  endtask
  task automatic test_internal();
    setup(1'b0, 1'b0, 1000, 100);
    bus.i_run = 1'b1;
    clear();
    measure(4500);
    n_tests++; if (fs_q.size() !== 5) begin n_fail++; $display("FAIL int_frames: got %0d exp 5", fs_q.size()); end
    n_tests++; if (fs_at(0) !== 1) begin n_fail++; $display("FAIL int_latency: got %0d exp 1", fs_at(0)); end
    for (int k = 1; k < 5; k++) begin
      n_tests++; if (fs_at(k) - fs_at(k-1) !== 1000) begin n_fail++; $display("FAIL int_period%0d: got %0d exp 1000", k, fs_at(k) - fs_at(k-1)); end
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (w_at(k) !== 100) begin n_fail++; $display("FAIL int_width%0d: got %0d exp 100", k, w_at(k)); end
    end
    n_tests++; if (bus.o_frame_cnt !== 16'd5) begin n_fail++; $display("FAIL int_cnt: got %0d exp 5", bus.o_frame_cnt); end
    stop();
    n_tests++; if (bus.o_trig !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL int_stop: got trig %0b busy %0b exp 0 0", bus.o_trig, bus.o_busy); end
  endtask
  task automatic test_clamp();
    setup(1'b0, 1'b0, 20, 50);
    bus.i_run = 1'b1;
    clear();
    measure(60);
    n_tests++; if (fs_q.size() !== 3 || fs_at(1) - fs_at(0) !== 20) begin n_fail++; $display("FAIL clamp20_period: got %0d frames delta %0d exp 3 20", fs_q.size(), fs_at(1) - fs_at(0)); end
    n_tests++; if (w_at(0) !== 19 || w_at(2) !== 19) begin n_fail++; $display("FAIL clamp20_width: got %0d/%0d exp 19", w_at(0), w_at(2)); end
    stop();
    setup(1'b0, 1'b0, 0, 50);
    bus.i_run = 1'b1;
    clear();
    measure(10);
    n_tests++; if (fs_q.size() !== 5 || fs_at(0) !== 1 || fs_at(4) !== 9) begin n_fail++; $display("FAIL clamp0_period: got %0d frames first %0d last %0d exp 5 1 9", fs_q.size(), fs_at(0), fs_at(4)); end
    n_tests++; if (w_at(0) !== 1 || w_at(4) !== 1) begin n_fail++; $display("FAIL clamp0_width: got %0d/%0d exp 1", w_at(0), w_at(4)); end
    n_tests++; if (bus.o_frame_cnt !== 16'd5) begin n_fail++; $display("FAIL clamp0_cnt: got %0d exp 5", bus.o_frame_cnt); end
    stop();
    setup(1'b0, 1'b0, 10, 0);
    bus.i_run = 1'b1;
    clear();
    measure(25);
    n_tests++; if (fs_q.size() !== 3 || w_at(0) !== 0 || w_at(2) !== 0) begin n_fail++; $display("FAIL zero_width: got %0d frames widths %0d/%0d exp 3 0 0", fs_q.size(), w_at(0), w_at(2)); end
    stop();
  endtask
  task automatic test_shadow();
    setup(1'b0, 1'b0, 100, 30);
    bus.i_run = 1'b1;
    clear();
    measure(50);
    bus.i_pulse = 12'd60;
    measure(150);
    n_tests++; if (fs_q.size() !== 2 || fs_at(1) !== 101) begin n_fail++; $display("FAIL shadow_frames: got %0d second at %0d exp 2 101", fs_q.size(), fs_at(1)); end
    n_tests++; if (w_at(0) !== 30) begin n_fail++; $display("FAIL shadow_cur: got %0d exp 30", w_at(0)); end
    n_tests++; if (w_at(1) !== 60) begin n_fail++; $display("FAIL shadow_next: got %0d exp 60", w_at(1)); end
    stop();
  endtask
  task automatic test_ext();
    setup(1'b1, 1'b1, 1000, 20);
    bus.i_ext_trig = 1'b0;
    repeat (5) tick();
    bus.i_run = 1'b1;
    tick();
    n_tests++; if (bus.o_busy !== 1'b1 || bus.o_frame_cnt !== 16'd0 || bus.o_frame_start !== 1'b0) begin n_fail++; $display("FAIL ext_enter: got busy %0b cnt %0d fs %0b exp 1 0 0", bus.o_busy, bus.o_frame_cnt, bus.o_frame_start); end
    clear();
    bus.i_ext_trig = 1'b1;
    measure(10);
    n_tests++; if (fs_q.size() !== 0) begin n_fail++; $display("FAIL ext_rise_ignored: got %0d frames exp 0", fs_q.size()); end
    clear();
    bus.i_ext_trig = 1'b0;
    measure(5);
    bus.i_ext_trig = 1'b1;
    measure(2);
    bus.i_ext_trig = 1'b0;
    measure(8);
    bus.i_ext_trig = 1'b1;
    measure(5);
    bus.i_ext_trig = 1'b0;
    measure(20);
    n_tests++; if (fs_at(0) !== 4) begin n_fail++; $display("FAIL ext_fall_latency: got %0d exp 4", fs_at(0)); end
    n_tests++; if (fs_q.size() !== 1) begin n_fail++; $display("FAIL ext_ignore_in_pulse: got %0d frames exp 1", fs_q.size()); end
    n_tests++; if (w_at(0) !== 20) begin n_fail++; $display("FAIL ext_width: got %0d exp 20", w_at(0)); end
    n_tests++; if (bus.o_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL ext_cnt: got %0d exp 1", bus.o_frame_cnt); end
    bus.i_ext_trig = 1'b1;
    measure(5);
    bus.i_ext_trig = 1'b0;
    measure(10);
    n_tests++; if (fs_q.size() !== 2 || fs_at(1) !== 49) begin n_fail++; $display("FAIL ext_rearm: got %0d frames second at %0d exp 2 49", fs_q.size(), fs_at(1)); end
    stop();
  endtask
  task automatic test_stop();
    setup(1'b0, 1'b0, 200, 100);
    bus.i_run = 1'b1;
    clear();
    measure(210);
    n_tests++; if (bus.o_frame_cnt !== 16'd2 || bus.o_trig !== 1'b1) begin n_fail++; $display("FAIL stop_pre: got cnt %0d trig %0b exp 2 1", bus.o_frame_cnt, bus.o_trig); end
    stop();
    n_tests++; if (bus.o_trig !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_frame_start !== 1'b0) begin n_fail++; $display("FAIL stop_trunc: got trig %0b busy %0b fs %0b exp 0 0 0", bus.o_trig, bus.o_busy, bus.o_frame_start); end
    bus.i_run = 1'b1;
    tick();
    n_tests++; if (bus.o_frame_start !== 1'b1 || bus.o_frame_cnt !== 16'd1 || bus.o_trig !== 1'b1) begin n_fail++; $display("FAIL rerun: got fs %0b cnt %0d trig %0b exp 1 1 1", bus.o_frame_start, bus.o_frame_cnt, bus.o_trig); end
    stop();
    setup(1'b0, 1'b0, 20, 5);
    bus.i_run = 1'b1;
    clear();
    measure(20);
    stop();
    n_tests++; if (bus.o_frame_start !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL stop_wins: got fs %0b busy %0b cnt %0d exp 0 0 1", bus.o_frame_start, bus.o_busy, bus.o_frame_cnt); end
  endtask
  task automatic test_wrap();
    setup(1'b0, 1'b0, 50, 10);
    bus.i_run = 1'b1;
    clear();
    measure(20);
    force dut.frame_cnt = 16'hffff;
    #1;
    release dut.frame_cnt;
    measure(35);
    n_tests++; if (fs_at(1) !== 51) begin n_fail++; $display("FAIL wrap_frame: got %0d exp 51", fs_at(1)); end
    n_tests++; if (bus.o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL wrap_cnt: got %0d exp 0", bus.o_frame_cnt); end
    n_tests++; if (bus.o_trig !== 1'b1) begin n_fail++; $display("FAIL wrap_trig: got %0b exp 1", bus.o_trig); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_trig !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_frame_start !== 1'b0) begin n_fail++; $display("FAIL async_reset: got trig %0b busy %0b fs %0b exp 0 0 0", bus.o_trig, bus.o_busy, bus.o_frame_start); end
    bus.i_run = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask
  initial begin
    test_reset();
    test_startup();
    test_internal();
    test_clamp();
    test_shadow();
    test_ext();
    test_stop();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
